// File: rtl/phy_rx_detect.sv
// PHY receiver-detect sequencer: settle, charge and debounced sample of the
// per-lane detect comparators, with periodic retry until a load is found.
module phy_rx_detect #(
    parameter int NUM_LANES        = 4,
    parameter int CM_SETTLE_CYCLES = 8,
    parameter int CHARGE_CYCLES    = 16,
    parameter int SAMPLE_CYCLES    = 4,
    parameter int RETRY_CYCLES     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 detect_req_i,
    input  logic [NUM_LANES-1:0] phy_rx_status_i,
    output logic                 tx_elec_idle_o,
    output logic                 tx_detect_rx_o,
    output logic                 any_phy_lane_detect_o,
    output logic [NUM_LANES-1:0] lane_detected_o,
    output logic                 busy_o
);

    localparam int MAX_A = (CM_SETTLE_CYCLES > CHARGE_CYCLES) ?
                           CM_SETTLE_CYCLES : CHARGE_CYCLES;
    localparam int MAX_B = (SAMPLE_CYCLES > RETRY_CYCLES) ?
                           SAMPLE_CYCLES : RETRY_CYCLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] CM_LOAD = CNT_W'(CM_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CH_LOAD = CNT_W'(CHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SA_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RT_LOAD = CNT_W'(RETRY_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CM_SETTLE,
        CHARGE,
        SAMPLE,
        EVAL,
        RETRY,
        WAIT_DROP
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_LANES-1:0] acc_q;
    logic                 eval_hit_q;
    logic                 abort;
    logic                 cnt_done;
    logic [NUM_LANES-1:0] acc_next;

    assign abort    = !detect_req_i && (state_q != IDLE) && (state_q != WAIT_DROP);
    assign cnt_done = (cnt_q == '0);
    assign acc_next = acc_q & phy_rx_status_i;

    // A request dropped during EVAL suppresses the pulse in that same cycle.
    assign any_phy_lane_detect_o = eval_hit_q & detect_req_i;
    assign tx_elec_idle_o        = 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            acc_q           <= '0;
            eval_hit_q      <= 1'b0;
            lane_detected_o <= '0;
            tx_detect_rx_o  <= 1'b0;
            busy_o          <= 1'b0;
        end else if (abort) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            eval_hit_q     <= 1'b0;
            tx_detect_rx_o <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            eval_hit_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (detect_req_i) begin
                        state_q <= CM_SETTLE;
                        cnt_q   <= CM_LOAD;
                        busy_o  <= 1'b1;
                    end
                end
                CM_SETTLE: begin
                    if (cnt_done) begin
                        state_q        <= CHARGE;
                        cnt_q          <= CH_LOAD;
                        tx_detect_rx_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                CHARGE: begin
                    if (cnt_done) begin
                        state_q <= SAMPLE;
                        cnt_q   <= SA_LOAD;
                        acc_q   <= '1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SAMPLE: begin
                    acc_q <= acc_next;
                    if (cnt_done) begin
                        state_q        <= EVAL;
                        tx_detect_rx_o <= 1'b0;
                        eval_hit_q     <= |acc_next;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                EVAL: begin
                    lane_detected_o <= acc_q;
                    if (|acc_q) begin
                        state_q <= WAIT_DROP;
                    end else begin
                        state_q <= RETRY;
                        cnt_q   <= RT_LOAD;
                    end
                end
                RETRY: begin
                    if (cnt_done) begin
                        state_q <= CM_SETTLE;
                        cnt_q   <= CM_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WAIT_DROP: begin
                    if (!detect_req_i) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    tx_detect_rx_o <= 1'b0;
                    busy_o         <= 1'b0;
                end
            endcase
        end
    end

endmodule
